// File: rtl/display_pkg.sv
// display_pkg: shared seven-segment constants for the display driver
package display_pkg;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [1:0] AN_OFF = 2'b11;
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
endpackage

// File: rtl/hex_to_seg.sv
// hex_to_seg: 4-bit nibble to active-low {g..a} segment pattern
module hex_to_seg
  import display_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_SEG[nib];
endmodule

// File: rtl/seg_display_driver.sv
// seg_display_driver: two-digit multiplexed hex display with halt blinking
module seg_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLINK_PERIOD = 256
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [7:0] load_data,
  input  logic       halt,
  output logic [6:0] seg,
  output logic [1:0] an
);
  localparam int RW = REFRESH_DIV > 2 ? $clog2(REFRESH_DIV) : 1;
  localparam int BW = BLINK_PERIOD > 2 ? $clog2(BLINK_PERIOD) : 1;
  logic [7:0] disp_val, val_nx;
  logic [RW-1:0] ref_cnt, ref_nx;
  logic [BW-1:0] blink_cnt, blink_nx;
  logic dsel, dsel_nx, blink_ph, ph_nx, ref_tc, blink_wrap, blank;
  logic [6:0] hex_seg;
  // next-state view shared by the registers and the output encoder
  always_comb begin
    ref_tc = ref_cnt == RW'(REFRESH_DIV - 1);
    blink_wrap = ref_tc && blink_cnt == BW'(BLINK_PERIOD - 1);
    ref_nx = ref_tc ? '0 : ref_cnt + RW'(1);
    dsel_nx = dsel ^ ref_tc;
    val_nx = load ? load_data : disp_val;
    blink_nx = !halt || blink_wrap ? '0 : blink_cnt + BW'(ref_tc);
    ph_nx = halt && (blink_ph ^ blink_wrap);
    blank = halt && ph_nx;
  end
  hex_to_seg u_hex (
    .nib(dsel_nx ? val_nx[7:4] : val_nx[3:0]),
    .seg(hex_seg)
  );
  // state and registered outputs, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      disp_val <= '0;
      ref_cnt <= '0;
      dsel <= 1'b0;
      blink_cnt <= '0;
      blink_ph <= 1'b0;
      seg <= SEG_BLANK;
      an <= AN_OFF;
    end else begin
      disp_val <= val_nx;
      ref_cnt <= ref_nx;
      dsel <= dsel_nx;
      blink_cnt <= blink_nx;
      blink_ph <= ph_nx;
      seg <= blank ? SEG_BLANK : hex_seg;
      an <= blank ? AN_OFF : dsel_nx ? 2'b01 : 2'b10;
    end
  end
endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: directed scoreboard bench for seg_display_driver
module tb_seg_display_driver;
  localparam int RD = 4;
  localparam int BP = 2;
  logic clk, rst, load, halt;
  logic [7:0] load_data;
  logic [6:0] seg;
  logic [1:0] an;
  logic [6:0] hex_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };
  logic [8:0] sb [$];
  int n_chk = 0;
  int n_fail = 0;
  logic [7:0] m_val;
  int m_ref, m_bc;
  logic m_dsel, m_ph;

  seg_display_driver #(.REFRESH_DIV(RD), .BLINK_PERIOD(BP)) dut (
    .clk(clk), .rst(rst), .load(load), .load_data(load_data),
    .halt(halt), .seg(seg), .an(an)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_val = 0; m_ref = 0; m_bc = 0; m_dsel = 0; m_ph = 0;
  endtask

  task automatic step(input logic ld, input logic [7:0] d, input logic h);
    logic tc, wrap, blank;
    logic [8:0] exp, got;
    load = ld; load_data = d; halt = h;
    tc = m_ref == RD - 1;
    wrap = tc && m_bc == BP - 1;
    m_ref = tc ? 0 : m_ref + 1;
    m_dsel = m_dsel ^ tc;
    if (ld) m_val = d;
    if (h) begin
      m_bc = wrap ? 0 : m_bc + int'(tc);
      m_ph = m_ph ^ wrap;
    end else begin
      m_bc = 0;
      m_ph = 0;
    end
    blank = h && m_ph;
    exp = blank ? {2'b11, 7'h7f} : {m_dsel ? 2'b01 : 2'b10, hex_tab[m_dsel ? m_val[7:4] : m_val[3:0]]};
    sb.push_back(exp);
    @(posedge clk);
    #1;
    got = {an, seg};
    if (sb.size() == 0) check("scoreboard_empty", 9'd1, 9'd0);
    else check("scoreboard", got, sb.pop_front());
  endtask

  task automatic do_reset();
    #2 rst = 0;
    #1 check("reset_async", {an, seg}, {2'b11, 7'h7f});
    repeat (3) @(posedge clk);
    #1 check("reset_held", {an, seg}, {2'b11, 7'h7f});
    #3 rst = 1;
    model_reset();
  endtask

  initial begin
    int blanks;
    rst = 1; load = 0; load_data = 0; halt = 0;
    model_reset();
    #3;
    do_reset();
    step(0, 8'h00, 0);
    check("first_edge", {an, seg}, {2'b10, 7'b1000000});
    step(1, 8'hA5, 0);
    check("load_digit0", {an, seg}, {2'b10, 7'b0010010});
    step(0, 8'h00, 0);
    step(0, 8'h00, 0);
    check("switch_digit1", {an, seg}, {2'b01, 7'b0001000});
    repeat (7) step(0, 8'h00, 0);
    step(1, 8'h3C, 0);
    check("load_and_toggle", {an, seg}, {2'b01, 7'b0110000});
    for (int i = 0; i < 16; i++) begin
      step(1, {i[3:0], i[3:0]}, 0);
      repeat (5) step(0, 8'h00, 0);
    end
    step(1, 8'h42, 1);
    repeat (15) step(0, 8'h00, 1);
    blanks = 0;
    for (int i = 0; i < 32; i++) begin
      step(0, 8'h00, 1);
      if (an == 2'b11) blanks++;
    end
    check("blink_duty", 9'(blanks), 9'd16);
    for (int i = 0; i < 40 && !m_ph; i++) step(0, 8'h00, 1);
    check("in_blank_phase", {8'd0, m_ph}, 9'd1);
    step(0, 8'h00, 0);
    check("halt_drop_visible", {8'd0, an != 2'b11}, 9'd1);
    step(0, 8'h00, 1);
    for (int i = 0; i < 40 && !m_ph; i++) step(0, 8'h00, 1);
    do_reset();
    for (int i = 0; i < 7; i++) begin
      step(0, 8'h00, 1);
      check("post_reset_visible", {an != 2'b11, seg}, {1'b1, 7'b1000000});
    end
    step(0, 8'h00, 1);
    check("blink_resumes", {an, seg}, {2'b11, 7'h7f});
    repeat (10) step(0, 8'h00, 1);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
